// File: rtl/modexp_pkg.sv
// Shared types and constants for the modular exponentiation engine and its
// Montgomery multiplier.
package modexp_pkg;
    localparam int WIDTH     = 1024;
    localparam int ELEN_W    = 11;
    localparam int MONT_STEP = 128;  // multiplier bits retired per cycle

    typedef enum logic [2:0] {IDLE, PRE, SQR, MUL, POST, FIN} state_e;
    typedef enum logic [1:0] {RST, GO, WAIT} phase_e;
    typedef enum logic [2:0] {OPND_X, OPND_R2, OPND_ACC, OPND_XT, OPND_ONE} opnd_e;
endpackage

// File: rtl/modexp_if.sv
// Request/response bundle between an RSA client and the modexp engine.
interface modexp_if;
    import modexp_pkg::*;

    logic              start;
    logic [WIDTH-1:0]  in_x;
    logic [WIDTH-1:0]  in_e;
    logic [ELEN_W-1:0] in_e_len;
    logic [WIDTH-1:0]  in_m;
    logic [WIDTH-1:0]  in_r_mod_m;
    logic [WIDTH-1:0]  in_r2_mod_m;
    logic [WIDTH-1:0]  result;
    logic              done;
    logic              busy;

    modport master (output start, in_x, in_e, in_e_len, in_m, in_r_mod_m, in_r2_mod_m,
                    input  result, done, busy);
    modport slave  (input  start, in_x, in_e, in_e_len, in_m, in_r_mod_m, in_r2_mod_m,
                    output result, done, busy);
endinterface

// File: rtl/modexp_montgomery.sv
// Radix-2 Montgomery multiplier: result = a*b*2^-WIDTH mod m, for a, b < m and m odd.
// Retires MONT_STEP bits of a per cycle, then one final conditional subtraction.
module montgomery
    import modexp_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_m,
    output logic [WIDTH-1:0] result,
    output logic             done
);
    localparam int N_ITER = WIDTH / MONT_STEP;
    localparam int CNT_W  = $clog2(N_ITER);

    typedef enum logic [1:0] {M_IDLE, M_RUN, M_FIX} mstate_e;

    mstate_e          state_q, state_d;
    logic [WIDTH+1:0] t_q, t_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    always_comb begin
        state_d  = state_q;
        t_d      = t_q;
        a_d      = a_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = 1'b0;
        unique case (state_q)
            M_IDLE: if (start) begin
                t_d     = '0;
                a_d     = in_a;
                cnt_d   = '0;
                state_d = M_RUN;
            end
            M_RUN: begin
                // Partial sum stays below 2m, so two guard bits cover t + b + m.
                for (int j = 0; j < MONT_STEP; j++) begin
                    if (a_d[0]) t_d = t_d + {2'b00, in_b};
                    if (t_d[0]) t_d = t_d + {2'b00, in_m};
                    t_d = t_d >> 1;
                    a_d = a_d >> 1;
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N_ITER - 1)) state_d = M_FIX;
            end
            default: begin
                result_d = (t_q >= {2'b00, in_m}) ? WIDTH'(t_q - {2'b00, in_m}) : WIDTH'(t_q);
                done_d   = 1'b1;
                state_d  = M_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= M_IDLE;
            t_q      <= '0;
            a_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            t_q      <= t_d;
            a_q      <= a_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign result = result_q;
    assign done   = done_q;
endmodule

// File: rtl/modexp.sv
// Left-to-right square-and-multiply x^e mod m in the Montgomery domain, sequencing
// one montgomery instance through PRE, SQR/MUL per exponent bit, and POST.
module modexp
    import modexp_pkg::*;
(
    input  logic     clk,
    input  logic     resetn,
    modexp_if.slave  bus
);
    state_e            state_q, state_d;
    phase_e            phase_q, phase_d;
    logic [WIDTH-1:0]  x_q, x_d, m_q, m_d, r_q, r_d, r2_q, r2_d, e_q, e_d;
    logic [WIDTH-1:0]  acc_q, acc_d, xt_q, xt_d, result_q, result_d;
    logic [ELEN_W-1:0] cnt_q, cnt_d, len_clamped;
    logic              mont_done_q, mont_done_d;

    opnd_e             sel_a, sel_b;
    logic [WIDTH-1:0]  mont_a, mont_b, mont_result;
    logic              mont_start, mont_done, mont_resetn;

    assign len_clamped = (bus.in_e_len > ELEN_W'(WIDTH)) ? ELEN_W'(WIDTH) : bus.in_e_len;
    // The multiplier sits in reset whenever the phase is RST, which includes IDLE and FIN.
    assign mont_resetn = resetn && (phase_q != RST);
    assign mont_start  = (phase_q == GO);

    always_comb begin
        sel_a = OPND_ACC;
        sel_b = OPND_ONE;
        unique case (state_q)
            PRE: begin
                sel_a = OPND_X;
                sel_b = OPND_R2;
            end
            SQR:     sel_b = OPND_ACC;
            MUL:     sel_b = OPND_XT;
            default: ;
        endcase
        mont_a = (sel_a == OPND_X) ? x_q : acc_q;
        unique case (sel_b)
            OPND_R2:  mont_b = r2_q;
            OPND_ACC: mont_b = acc_q;
            OPND_XT:  mont_b = xt_q;
            default:  mont_b = WIDTH'(1);
        endcase
    end

    always_comb begin
        // NOTE: every combinational target gets its hold value first; with blocking
        // assignments and full defaults no latch can be inferred.
        state_d     = state_q;
        phase_d     = phase_q;
        x_d         = x_q;
        m_d         = m_q;
        r_d         = r_q;
        r2_d        = r2_q;
        e_d         = e_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        xt_d        = xt_q;
        result_d    = result_q;
        mont_done_d = mont_done;
        unique case (state_q)
            IDLE: if (bus.start) begin
                x_d     = bus.in_x;
                m_d     = bus.in_m;
                r_d     = bus.in_r_mod_m;
                r2_d    = bus.in_r2_mod_m;
                // Align bit in_e_len-1 to the MSB so bits are always consumed from the top.
                e_d     = bus.in_e << (ELEN_W'(WIDTH) - len_clamped);
                cnt_d   = len_clamped;
                phase_d = RST;
                state_d = PRE;
            end
            FIN: state_d = IDLE;
            default: begin
                unique case (phase_q)
                    RST: phase_d = GO;
                    GO:  phase_d = WAIT;
                    default: if (mont_done_q) begin
                        phase_d = RST;
                        unique case (state_q)
                            PRE: begin
                                xt_d    = mont_result;
                                acc_d   = r_q;
                                state_d = (cnt_q != '0) ? SQR : POST;
                            end
                            SQR: begin
                                acc_d = mont_result;
                                if (e_q[WIDTH-1]) begin
                                    state_d = MUL;
                                end else begin
                                    cnt_d   = cnt_q - ELEN_W'(1);
                                    e_d     = e_q << 1;
                                    state_d = (cnt_q != ELEN_W'(1)) ? SQR : POST;
                                end
                            end
                            MUL: begin
                                acc_d   = mont_result;
                                cnt_d   = cnt_q - ELEN_W'(1);
                                e_d     = e_q << 1;
                                state_d = (cnt_q != ELEN_W'(1)) ? SQR : POST;
                            end
                            default: begin
                                result_d = mont_result;
                                state_d  = FIN;
                            end
                        endcase
                    end
                endcase
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            phase_q     <= RST;
            x_q         <= '0;
            m_q         <= '0;
            r_q         <= '0;
            r2_q        <= '0;
            e_q         <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            xt_q        <= '0;
            result_q    <= '0;
            mont_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            x_q         <= x_d;
            m_q         <= m_d;
            r_q         <= r_d;
            r2_q        <= r2_d;
            e_q         <= e_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            xt_q        <= xt_d;
            result_q    <= result_d;
            mont_done_q <= mont_done_d;
        end
    end

    montgomery u_mont (
        .clk    (clk),
        .resetn (mont_resetn),
        .start  (mont_start),
        .in_a   (mont_a),
        .in_b   (mont_b),
        .in_m   (m_q),
        .result (mont_result),
        .done   (mont_done)
    );

    assign bus.result = result_q;
    assign bus.done   = (state_q == FIN);
    assign bus.busy   = (state_q != IDLE);
endmodule

// File: tb/tb_modexp.sv
// Scoreboard bench for modexp: stimulus pushes model results, a negedge monitor pops
// them on done and also checks operation count and total latency.
module tb_modexp;
    import modexp_pkg::*;

    typedef logic [WIDTH-1:0] word_t;
    typedef struct {
        word_t res;
        int    n_ops;
        int    start_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    modexp_if bus();

    modexp dut (.clk(clk), .resetn(resetn), .bus(bus));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   mont_starts = 0;
    int   go_cyc = 0;
    int   lm_meas = 0;
    bit   busy_fall_pending = 1'b0;

    task automatic check(input string name, input word_t act, input word_t exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (low 128 bits)", name, act[127:0], exp[127:0]);
        end
    endtask

    function automatic word_t mulmod(input word_t a, input word_t b, input word_t m);
        logic [2*WIDTH-1:0] p;
        p = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        return word_t'(p % {{WIDTH{1'b0}}, m});
    endfunction

    function automatic int eff_len(input int len);
        return (len > WIDTH) ? WIDTH : len;
    endfunction

    function automatic word_t powmod(input word_t x, input word_t e, input word_t m, input int len);
        word_t r;
        r = word_t'(1);
        for (int i = eff_len(len) - 1; i >= 0; i--) begin
            r = mulmod(r, r, m);
            if (e[i]) r = mulmod(r, x, m);
        end
        return r;
    endfunction

    function automatic int n_ops_of(input word_t e, input int len);
        int n;
        n = 2 + eff_len(len);
        for (int i = 0; i < eff_len(len); i++) n += int'(e[i]);
        return n;
    endfunction

    function automatic word_t r_mod(input word_t m);
        logic [WIDTH:0] big;
        big = '0;
        big[WIDTH] = 1'b1;
        return word_t'(big % {1'b0, m});
    endfunction

    function automatic word_t rand_wide();
        word_t v;
        for (int i = 0; i < WIDTH / 32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    // Monitor: counts instance operations, measures Lm, and scores every done pulse.
    always @(negedge clk) begin
        exp_t ent;
        if (!resetn) begin
            mont_starts = 0;
            busy_fall_pending = 1'b0;
        end else begin
            if (busy_fall_pending) begin
                check("busy_fall", word_t'(bus.busy), '0);
                busy_fall_pending = 1'b0;
            end
            if (dut.u_mont.start) begin
                mont_starts++;
                go_cyc = cyc;
            end
            if (dut.u_mont.done) lm_meas = cyc - go_cyc;
            if (bus.done) begin
                check("done_expected", word_t'(sb.size() != 0), word_t'(1));
                if (sb.size() != 0) begin
                    ent = sb.pop_front();
                    check("result", bus.result, ent.res);
                    check("mont_ops", word_t'(mont_starts), word_t'(ent.n_ops));
                    check("latency", word_t'(cyc - ent.start_cyc + 1),
                          word_t'(2 + ent.n_ops * (lm_meas + 3)));
                end
                mont_starts = 0;
                busy_fall_pending = 1'b1;
            end
        end
    end

    task automatic drive(input word_t x, input word_t e, input word_t m, input int len);
        word_t rm;
        rm = r_mod(m);
        bus.in_x        = x;
        bus.in_e        = e;
        bus.in_m        = m;
        bus.in_e_len    = ELEN_W'(len);
        bus.in_r_mod_m  = rm;
        bus.in_r2_mod_m = mulmod(rm, rm, m);
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after the start pulse.
    task automatic issue(input word_t x, input word_t e, input word_t m, input int len,
                         input word_t exp_res);
        exp_t ent;
        drive(x, e, m, len);
        ent.res       = exp_res;
        ent.n_ops     = n_ops_of(e, len);
        ent.start_cyc = cyc;
        sb.push_back(ent);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("done_seen", word_t'(sb.size()), '0);
        sb.delete();
        @(posedge clk); #1;
    endtask

    task automatic run(input word_t x, input word_t e, input word_t m, input int len,
                       input word_t exp_res);
        issue(x, e, m, len, exp_res);
        @(negedge clk);
        check("busy_high", word_t'(bus.busy), word_t'(1));
        @(posedge clk); #1;
        wait_done(n_ops_of(e, len) * 30 + 50);
    endtask

    initial begin
        word_t x, e, m;
        int    len;

        bus.start = 1'b0;
        drive(word_t'(0), word_t'(0), word_t'(7), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_result", bus.result, '0);
        check("rst_done", word_t'(bus.done), '0);
        check("rst_busy", word_t'(bus.busy), '0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;

        run(word_t'(4), word_t'(13), word_t'(497), 4, word_t'(445));
        run(word_t'(3), word_t'(3), word_t'(7), 4, word_t'(6));
        run(word_t'(3), word_t'(3), word_t'(7), 2, word_t'(6));
        run(word_t'(5), word_t'(0), word_t'(7), 0, word_t'(1));

        // A start 100 cycles into a run, with new operands left on the bus, must be ignored.
        issue(word_t'(4), word_t'(13), word_t'(497), 4, word_t'(445));
        repeat (99) begin
            @(posedge clk); #1;
        end
        drive(word_t'(5), word_t'(7), word_t'(11), 3);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(200);
        repeat (40) begin
            @(posedge clk); #1;
        end

        // Abort mid-run with a one-cycle reset, then run again.
        issue(word_t'(3), word_t'(3), word_t'(7), 4, word_t'(6));
        repeat (40) begin
            @(posedge clk); #1;
        end
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        sb.delete();
        @(negedge clk);
        check("abort_busy", word_t'(bus.busy), '0);
        check("abort_done", word_t'(bus.done), '0);
        check("abort_result", bus.result, '0);
        @(posedge clk); #1;
        run(word_t'(5), word_t'(6), word_t'(11), 3, powmod(word_t'(5), word_t'(6), word_t'(11), 3));

        // Random 1024-bit operands: two full-length exponents (one via an over-long
        // in_e_len that must clamp), the rest with short exponent lengths.
        for (int k = 0; k < 50; k++) begin
            m = rand_wide();
            m[0] = 1'b1;
            m[WIDTH-1] = 1'b1;
            x = rand_wide() % m;
            e = rand_wide();
            if (k == 0)      len = WIDTH;
            else if (k == 1) len = (1 << ELEN_W) - 1;
            else             len = int'($urandom_range(0, 24));
            run(x, e, m, len, powmod(x, e, m, len));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
